// File: rtl/edulent_out_capture.sv
// Output-port capture FIFO beside the edulent CPU: records every change of i_out.
// Optional CAPTURE_STAMP_EN stores a 16-bit cycle stamp with each captured byte.
module edulent_out_capture #(
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [7:0]       i_out,
   input  logic             i_cap_en,
   output logic [7:0]       o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_overflow,
`ifdef CAPTURE_STAMP_EN
   output logic [15:0]      o_stamp,
`endif
   input  logic             i_clr_ovf
);

   localparam int PTR_W = $clog2(DEPTH);

`ifdef CAPTURE_STAMP_EN
   localparam int ENT_W = 24;
`else
   localparam int ENT_W = 8;
`endif

   logic [7:0]       prev_q;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             cap;
   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic [ENT_W-1:0] wr_ent;
   logic [ENT_W-1:0] rd_ent;

`ifdef CAPTURE_STAMP_EN
   logic [15:0] cyc_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) cyc_q <= 16'h0000;
      else         cyc_q <= cyc_q + 16'h0001;
   end

   // Stamp is the counter value presented at the capture edge
   assign wr_ent  = {cyc_q, i_out};
   assign o_stamp = rd_ent[23:8];
`else
   assign wr_ent = i_out;
`endif

   assign full = (cnt_q == CNT_W'(DEPTH));
   assign cap  = i_cap_en && (i_out != prev_q);
   assign pop  = (cnt_q != '0) && i_ready;
   assign push = cap && (!full || pop);
   assign drop = cap && full && !pop;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) prev_q <= 8'h00;
      else         prev_q <= i_out;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= wr_ent;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case (1'b1)
            push && !pop: cnt_q <= cnt_q + CNT_W'(1);
            pop && !push: cnt_q <= cnt_q - CNT_W'(1);
            default:      cnt_q <= cnt_q;
         endcase
      end
   end

   // A drop in the same cycle as a clear keeps the flag set
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)        ovf_q <= 1'b0;
      else if (drop)      ovf_q <= 1'b1;
      else if (i_clr_ovf) ovf_q <= 1'b0;
   end

   assign rd_ent     = mem_q[rd_ptr_q];
   assign o_data     = rd_ent[7:0];
   assign o_valid    = (cnt_q != '0);
   assign o_count    = cnt_q;
   assign o_full     = full;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_edulent_out_capture.sv
// Directed bench for edulent_out_capture: vector table plus
// hand sequences for full/overflow, reset and stamp behaviour.
module tb_edulent_out_capture;

   logic       clk;
   logic       rst_n;
   logic [7:0] out;
   logic       cap_en;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic [3:0] count;
   logic       full;
   logic       ovf;
   logic       clr_ovf;
`ifdef CAPTURE_STAMP_EN
   logic [15:0] stamp;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   edulent_out_capture #(.DEPTH(8)) dut (
      .i_clk      (clk),
      .i_rstn     (rst_n),
      .i_out      (out),
      .i_cap_en   (cap_en),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_count    (count),
      .o_full     (full),
      .o_overflow (ovf),
`ifdef CAPTURE_STAMP_EN
      .o_stamp    (stamp),
`endif
      .i_clr_ovf  (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] out;
      logic       cap;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [7:0] d;
      logic [3:0] cnt;
      logic       full;
      logic       ovf;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] o, input logic c,
                       input logic r, input logic cl);
      out     = o;
      cap_en  = c;
      ready   = r;
      clr_ovf = cl;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q [$];
   int         bad;

   initial begin
      rst_n   = 1'b0;
      out     = 8'h00;
      cap_en  = 1'b1;
      ready   = 1'b0;
      clr_ovf = 1'b0;

      // {out, cap, rdy, clr, valid, data, count, full, ovf}
      tbl[0]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd1, 1'b0, 1'b0};
      tbl[1]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd1, 1'b0, 1'b0};
      tbl[2]  = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd2, 1'b0, 1'b0};
      tbl[3]  = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 4'd1, 1'b0, 1'b0};
      tbl[4]  = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[5]  = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[6]  = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[7]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[8]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 4'd1, 1'b0, 1'b0};
      tbl[9]  = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[10] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0};
      tbl[11] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 4'd2, 1'b0, 1'b0};
      tbl[12] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 4'd3, 1'b0, 1'b0};
      tbl[13] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 4'd2, 1'b0, 1'b0};
      tbl[14] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0};
      tbl[15] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst.valid", valid, 0);
      chk("rst.count", count, 0);
      chk("rst.full", full, 0);
      chk("rst.ovf", ovf, 0);
      chk("rst.data", data, 8'h00);

      // Held zero never captures
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(8'h00, 1'b1, 1'b0, 1'b0);
         if (valid !== 1'b0 || count !== 4'd0) bad++;
      end
      chk("idle20.bad_cycles", bad, 0);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].out, tbl[i].cap, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("v%0d.valid", i), valid, tbl[i].v);
         chk($sformatf("v%0d.count", i), count, tbl[i].cnt);
         chk($sformatf("v%0d.full", i), full, tbl[i].full);
         chk($sformatf("v%0d.ovf", i), ovf, tbl[i].ovf);
         if (tbl[i].v)
            chk($sformatf("v%0d.data", i), data, tbl[i].d);
      end

      // Fill to 8, pointers wrap on the way
      for (int i = 0; i < 8; i++)
         step(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      chk("fill.count", count, 8);
      chk("fill.full", full, 1);
      chk("fill.ovf", ovf, 0);
      // Ninth byte dropped; set beats simultaneous clear
      step(8'h18, 1'b1, 1'b0, 1'b1);
      chk("ovf.count", count, 8);
      chk("ovf.set_wins", ovf, 1);
      chk("ovf.head", data, 8'h10);
      step(8'h18, 1'b1, 1'b0, 1'b1);
      chk("ovf.clear", ovf, 0);

      // Push into full FIFO with same-cycle pop
      step(8'h20, 1'b1, 1'b1, 1'b0);
      chk("fullpop.count", count, 8);
      chk("fullpop.ovf", ovf, 0);
      chk("fullpop.full", full, 1);

      exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d.valid", i), valid, 1);
         chk($sformatf("drain%0d.data", i), data, exp_q[i]);
         step(8'h20, 1'b1, 1'b1, 1'b0);
      end
      chk("drain.empty", valid, 0);
      chk("drain.count", count, 0);

      // Asynchronous reset with queued entries
      step(8'h41, 1'b1, 1'b0, 1'b0);
      step(8'h42, 1'b1, 1'b0, 1'b0);
      step(8'h43, 1'b1, 1'b0, 1'b0);
      chk("pre_rst.count", count, 3);
      rst_n = 1'b0;
      #2;
      chk("async_rst.valid", valid, 0);
      chk("async_rst.count", count, 0);
      out = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("post_rst.empty", valid, 0);
      step(8'h77, 1'b1, 1'b0, 1'b0);
      chk("post_rst.data", data, 8'h77);
      chk("post_rst.count", count, 1);
`ifdef CAPTURE_STAMP_EN
      chk("stamp.cycle10", stamp, 16'd10);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
